stepper_pulse_gen: RTL and testbench

Dual-axis step/direction pulse generator that sits directly downstream of the SCARA controller. It accepts one signed step-count pair (joint 1, joint 2) per command through a valid/ready handshake. It drives both stepper drivers concurrently on a shared step timebase and keeps signed cumulative position counters. It pulses done when both axes have finished.

---
 rtl/stepper_pulse_gen.sv | 200 ++++++++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_gen.sv
// Dual-axis step/direction pulse generator. One signed step-count pair is
// accepted per command. Both axes share one step timebase, and each axis keeps
// a signed cumulative position counter. done pulses when both axes finish.
module stepper_pulse_gen #(
    parameter int HALF_PERIOD = 2500,
    parameter int DIR_SETUP   = 50,
    parameter int POS_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       th1_steps,
    input  logic [8:0]       th2_steps,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             step1,
    output logic             dir1,
    output logic             step2,
    output logic             dir2,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos1,
    output logic [POS_W-1:0] pos2
);

    // One timer serves both the direction setup delay and the step period.
    localparam int TMR_MAX = (DIR_SETUP > 2 * HALF_PERIOD) ? DIR_SETUP : 2 * HALF_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0] SETUP_END = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] HALF_END  = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] PER_END   = TMR_W'(2 * HALF_PERIOD - 1);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Magnitude of a 9-bit two's complement request; -256 maps to 256.
    function automatic logic [8:0] abs9(input logic [8:0] v);
        abs9 = v[8] ? (~v + 9'd1) : v;
    endfunction

    state_t             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [8:0]         rem1_q, rem2_q;
    logic               step1_q, step2_q, dir1_q, dir2_q;
    logic               busy_q, done_q, cmd_ready_q;
    logic [POS_W-1:0]   pos1_q, pos2_q;

    logic [8:0]         mag1_d, mag2_d;
    logic               rem1_nz_d, rem2_nz_d;
    logic [8:0]         rem1_dec_d, rem2_dec_d;
    logic [POS_W-1:0]   pos1_nxt_d, pos2_nxt_d;
    logic               mag_zero_d, rem_fin_d;

    // End-of-period values: decremented counts and updated positions for pulsing axes.
    always_comb begin
        mag1_d     = abs9(th1_steps);
        mag2_d     = abs9(th2_steps);
        mag_zero_d = (mag1_d == 9'd0) && (mag2_d == 9'd0);
        rem1_nz_d  = (rem1_q != 9'd0);
        rem2_nz_d  = (rem2_q != 9'd0);
        if (rem1_nz_d) begin
            rem1_dec_d = rem1_q - 9'd1;
            pos1_nxt_d = dir1_q ? (pos1_q - POS_ONE) : (pos1_q + POS_ONE);
        end else begin
            rem1_dec_d = rem1_q;
            pos1_nxt_d = pos1_q;
        end
        if (rem2_nz_d) begin
            rem2_dec_d = rem2_q - 9'd1;
            pos2_nxt_d = dir2_q ? (pos2_q - POS_ONE) : (pos2_q + POS_ONE);
        end else begin
            rem2_dec_d = rem2_q;
            pos2_nxt_d = pos2_q;
        end
        rem_fin_d = (rem1_dec_d == 9'd0) && (rem2_dec_d == 9'd0);
    end

    // Command FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= TMR_ZERO;
            rem1_q      <= 9'd0;
            rem2_q      <= 9'd0;
            step1_q     <= 1'b0;
            step2_q     <= 1'b0;
            dir1_q      <= 1'b0;
            dir2_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            pos1_q      <= {POS_W{1'b0}};
            pos2_q      <= {POS_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dir1_q      <= th1_steps[8];
                        dir2_q      <= th2_steps[8];
                        rem1_q      <= mag1_d;
                        rem2_q      <= mag2_d;
                        timer_q     <= TMR_ZERO;
                        cmd_ready_q <= 1'b0;
                        if (mag_zero_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SETUP;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        timer_q     <= TMR_ZERO;
                    end else if (timer_q == SETUP_END) begin
                        // Step outputs rise on the same edge that enters RUN.
                        state_q <= ST_RUN;
                        timer_q <= TMR_ZERO;
                        step1_q <= rem1_nz_d;
                        step2_q <= rem2_nz_d;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // A truncated period is never counted in the positions.
                        state_q     <= ST_IDLE;
                        step1_q     <= 1'b0;
                        step2_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        timer_q     <= TMR_ZERO;
                    end else if (timer_q == PER_END) begin
                        rem1_q  <= rem1_dec_d;
                        rem2_q  <= rem2_dec_d;
                        pos1_q  <= pos1_nxt_d;
                        pos2_q  <= pos2_nxt_d;
                        timer_q <= TMR_ZERO;
                        if (rem_fin_d) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            step1_q <= 1'b0;
                            step2_q <= 1'b0;
                        end else begin
                            step1_q <= (rem1_dec_d != 9'd0);
                            step2_q <= (rem2_dec_d != 9'd0);
                        end
                    end else if (timer_q == HALF_END) begin
                        step1_q <= 1'b0;
                        step2_q <= 1'b0;
                        timer_q <= timer_q + TMR_ONE;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    timer_q     <= TMR_ZERO;
                    step1_q     <= 1'b0;
                    step2_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign step1     = step1_q;
    assign step2     = step2_q;
    assign dir1      = dir1_q;
    assign dir2      = dir2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pos1      = pos1_q;
    assign pos2      = pos2_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Testbench for stepper_pulse_gen: an offset-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_stepper_pulse_gen;

    localparam int HP = 2;
    localparam int DS = 3;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    th1_steps, th2_steps;
    logic          cmd_valid, abort;
    logic          cmd_ready, step1, dir1, step2, dir2, busy, done;
    logic [PW-1:0] pos1, pos2;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_rise1 = 0, n_rise2 = 0, n_busy = 0, n_done = 0;

    always #5 clk = ~clk;

    stepper_pulse_gen #(.HALF_PERIOD(HP), .DIR_SETUP(DS), .POS_W(PW)) dut (
        .clk(clk), .reset(reset),
        .th1_steps(th1_steps), .th2_steps(th2_steps),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
        .step1(step1), .dir1(dir1), .step2(step2), .dir2(dir2),
        .busy(busy), .done(done), .pos1(pos1), .pos2(pos2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit            m_act = 1'b0;
    int            m_start, m_n1, m_n2;
    bit            m_neg1, m_neg2;
    logic [PW-1:0] m_p01, m_p02;
    logic          e_ready, e_step1, e_step2, e_dir1, e_dir2, e_busy, e_done;
    logic [PW-1:0] e_pos1, e_pos2;

    // Phase of a command at offset o edges after acceptance:
    // 0 setup, 1 run, 2 done cycle, 3 finished.
    function automatic int ph_of(input int o, input int n1, input int n2);
        int mx, l;
        if (n1 == 0 && n2 == 0) return (o == 0) ? 2 : 3;
        mx = (n1 > n2) ? n1 : n2;
        l  = DS + mx * 2 * HP;
        if (o < DS) return 0;
        if (o < l) return 1;
        if (o == l) return 2;
        return 3;
    endfunction

    function automatic int periods_done(input int o, input int n1, input int n2);
        int mx, c;
        if ((n1 == 0 && n2 == 0) || o < DS) return 0;
        mx = (n1 > n2) ? n1 : n2;
        c  = (o - DS) / (2 * HP);
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic [PW-1:0] pos_at(input logic [PW-1:0] p0, input bit neg, input int n, input int c);
        int k;
        k = (c < n) ? c : n;
        return neg ? (p0 - PW'(k)) : (p0 + PW'(k));
    endfunction

    task automatic set_idle();
        e_ready = 1'b1; e_step1 = 1'b0; e_step2 = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic set_active(input int o);
        int ph, c, r;
        ph = ph_of(o, m_n1, m_n2);
        c  = periods_done(o, m_n1, m_n2);
        r  = o - DS;
        e_ready = 1'b0;
        e_busy  = (ph <= 1);
        e_done  = (ph == 2);
        e_step1 = (ph == 1) && ((r % (2 * HP)) < HP) && ((r / (2 * HP)) < m_n1);
        e_step2 = (ph == 1) && ((r % (2 * HP)) < HP) && ((r / (2 * HP)) < m_n2);
        e_pos1  = pos_at(m_p01, m_neg1, m_n1, c);
        e_pos2  = pos_at(m_p02, m_neg2, m_n2, c);
        e_dir1  = m_neg1;
        e_dir2  = m_neg2;
    endtask

    // Model update on each active edge from the inputs present at that edge.
    always @(posedge clk) begin
        int o;
        cyc = cyc + 1;
        if (!reset) begin
            m_act = 1'b0; e_pos1 = '0; e_pos2 = '0; e_dir1 = 1'b0; e_dir2 = 1'b0;
            set_idle();
        end else if (m_act) begin
            o = cyc - m_start;
            if (ph_of(o - 1, m_n1, m_n2) == 2) begin
                m_act = 1'b0; set_idle();
            end else if (abort) begin
                m_act = 1'b0; set_idle();   // positions keep completed periods only
            end else begin
                set_active(o);
            end
        end else if (cmd_valid) begin
            m_act = 1'b1; m_start = cyc;
            m_neg1 = th1_steps[8]; m_neg2 = th2_steps[8];
            m_n1 = th1_steps[8] ? 512 - int'(th1_steps) : int'(th1_steps);
            m_n2 = th2_steps[8] ? 512 - int'(th2_steps) : int'(th2_steps);
            m_p01 = e_pos1; m_p02 = e_pos2;
            set_active(0);
        end else begin
            set_idle();
        end
    end

    // Compare every cycle once reset has been applied.
    always @(negedge clk) begin
        if (cyc >= 1)
            check($sformatf("outputs@%0d", cyc),
                  {25'd0, cmd_ready, step1, dir1, step2, dir2, busy, done, pos1, pos2},
                  {25'd0, e_ready, e_step1, e_dir1, e_step2, e_dir2, e_busy, e_done, e_pos1, e_pos2});
    end

    always @(posedge step1) n_rise1 = n_rise1 + 1;
    always @(posedge step2) n_rise2 = n_rise2 + 1;
    always @(posedge busy)  n_busy  = n_busy + 1;
    always @(posedge done)  n_done  = n_done + 1;

    // ---------------- directed stimulus ----------------
    task automatic clr_counts();
        n_rise1 = 0; n_rise2 = 0; n_busy = 0; n_done = 0;
    endtask

    task automatic send(input logic [8:0] a, input logic [8:0] b, output int acc);
        th1_steps = a; th2_steps = b; cmd_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int acc, dc, guard;
        reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0; th1_steps = 9'd0; th2_steps = 9'd0;
        repeat (3) begin
            @(negedge clk);
            th1_steps = 9'($urandom); th2_steps = 9'($urandom);
            cmd_valid = 1'($urandom); abort = 1'($urandom);
        end
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_flags", {step1, dir1, step2, dir2, busy, done}, 6'd0);
        check("rst_pos", {pos1, pos2}, 32'd0);
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Basic: +3 / -2
        clr_counts();
        send(9'h003, 9'h1FE, acc);
        check("basic_dirs", {dir1, dir2}, 2'b01);
        wait_done(100, dc);
        check("basic_done_lat", dc - acc, 64'd15);
        check("basic_pos1", pos1, 16'h0003);
        check("basic_pos2", pos2, 16'hFFFE);
        @(negedge clk);
        check("basic_ready_back", cmd_ready, 1'b1);
        check("basic_pulses", {n_rise1[15:0], n_rise2[15:0]}, {16'd3, 16'd2});

        // Zero command
        clr_counts();
        send(9'h000, 9'h000, acc);
        wait_done(20, dc);
        check("zero_done_lat", dc - acc, 64'd0);
        @(negedge clk);
        check("zero_quiet", {n_rise1[7:0], n_rise2[7:0], n_busy[7:0]}, 24'd0);
        check("zero_pos", {pos1, pos2}, {16'h0003, 16'hFFFE});

        // Extremes: -256 / +255 from cleared positions
        pulse_reset();
        clr_counts();
        send(9'h100, 9'h0FF, acc);
        check("ext_dirs", {dir1, dir2}, 2'b10);
        wait_done(1100, dc);
        check("ext_done_lat", dc - acc, 64'd1027);
        check("ext_pos", {pos1, pos2}, {16'hFF00, 16'h00FF});
        check("ext_pulses", {n_rise1[15:0], n_rise2[15:0]}, {16'd256, 16'd255});
        @(negedge clk);

        // Abort during the high phase of the third pulse
        pulse_reset();
        clr_counts();
        send(9'h005, 9'h005, acc);
        while (cyc < acc + 11) @(negedge clk);
        check("abort_third_high", {step1, step2}, 2'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_steps_low", {step1, step2, busy}, 3'b000);
        check("abort_pos", {pos1, pos2}, {16'h0002, 16'h0002});
        check("abort_ready", cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("abort_no_done", n_done, 64'd0);
        // abort coinciding with an accept in IDLE is ignored
        abort = 1'b1;
        send(9'h001, 9'h001, acc);
        abort = 1'b0;
        check("abort_idle_accept", busy, 1'b1);
        wait_done(100, dc);
        check("abort_resume_lat", dc - acc, 64'd7);
        check("abort_resume_pos", {pos1, pos2}, {16'h0003, 16'h0003});
        @(negedge clk);

        // Handshake: cmd_valid held high with changing data
        th1_steps = 9'h002; th2_steps = 9'h001; cmd_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            th1_steps = 9'($urandom); th2_steps = 9'($urandom);
            @(negedge clk);
            guard++;
        end
        dc = (done === 1'b1) ? cyc : -1;
        check("hs_done_lat", dc - acc, 64'd11);
        check("hs_pos", {pos1, pos2}, {16'h0005, 16'h0004});
        th1_steps = 9'h001; th2_steps = 9'h1FF;
        @(negedge clk);
        check("hs_idle_gap", {busy, cmd_ready}, 2'b01);
        @(negedge clk);
        check("hs_next_accept", {busy, cmd_ready, dir2}, 3'b101);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_step", step1, 1'b1);
        pulse_reset();
        check("mid_rst_pos", {pos1, pos2}, 32'd0);
        check("mid_rst_flags", {cmd_ready, step1, step2, dir1, dir2, busy, done}, 7'b1000000);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
